// File: rtl/rr_merge_fifo_dataless_pkg.sv
// Shared helpers for the round-robin merge FIFO: width derivation,
// wrap-around increment and the FIFO operation encoding.
package rr_merge_fifo_dataless_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int idx_width(input int size);
        return (clog2(size) > 1) ? clog2(size) : 1;
    endfunction

    // Explicit compare keeps non-power-of-two limits correct.
    function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned limit);
        return (value == limit - 1) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/rr_merge_fifo_dataless_select.sv
// Combinational round-robin picker: first valid input at or after prio,
// wrapping past SIZE-1 back to 0.
module rr_priority_select
    import rr_merge_fifo_dataless_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int IDXW = 2
) (
    input  logic [SIZE-1:0] ins_valid,
    input  logic [IDXW-1:0] prio,
    output logic [IDXW-1:0] w,
    output logic            grant
);

    logic [2*SIZE-1:0] doubled;
    logic [SIZE-1:0]   rotated;
    int                first;
    int                pos;

    // Rotating a doubled copy puts the prio input at bit 0.
    always_comb begin
        doubled = {ins_valid, ins_valid};
        rotated = SIZE'(doubled >> prio);
        first   = 0;
        grant   = 1'b0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                first = i;
                grant = 1'b1;
            end
        end
        pos = int'(prio) + first;
        if (pos >= SIZE) begin
            pos = pos - SIZE;
        end
        w = IDXW'(pos);
    end

endmodule

// File: rtl/rr_merge_fifo_dataless.sv
// Round-robin merge of SIZE dataless channels into one token FIFO that
// remembers which input each token came from.
module rr_merge_fifo_dataless
    import rr_merge_fifo_dataless_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int SLOTS = 4,
    localparam int IDXW = idx_width(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] ins_valid,
    output logic [SIZE-1:0] ins_ready,
    output logic            outs_valid,
    input  logic            outs_ready,
    output logic [IDXW-1:0] index
);

    localparam int PTRW = (clog2(SLOTS) > 1) ? clog2(SLOTS) : 1;
    localparam int CNTW = clog2(SLOTS + 1);

    logic [IDXW-1:0] prio_q, prio_d;
    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [IDXW-1:0] tag_q [SLOTS];
    logic [IDXW-1:0] tag_d [SLOTS];

    logic [IDXW-1:0] w;
    logic            grant;
    logic            space;
    logic            write_en;
    logic            read_en;
    fifo_op_e        op;

    rr_priority_select #(
        .SIZE (SIZE),
        .IDXW (IDXW)
    ) u_select (
        .ins_valid (ins_valid),
        .prio      (prio_q),
        .w         (w),
        .grant     (grant)
    );

    // A full FIFO still accepts when the head is being drained this cycle.
    always_comb begin
        space    = (count_q != CNTW'(SLOTS)) || outs_ready;
        write_en = grant && space && !rst;
        read_en  = outs_ready && (count_q != '0);
        op       = fifo_op_e'({write_en, read_en});

        ins_ready = '0;
        if (write_en) begin
            ins_ready[w] = 1'b1;
        end

        prio_d = prio_q;
        head_d = head_q;
        tail_d = tail_q;
        tag_d  = tag_q;
        if (write_en) begin
            tag_d[tail_q] = w;
            tail_d        = PTRW'(wrap_inc(32'(tail_q), SLOTS));
            prio_d        = IDXW'(wrap_inc(32'(w), SIZE));
        end
        if (read_en) begin
            head_d = PTRW'(wrap_inc(32'(head_q), SLOTS));
        end

        case (op)
            OP_WRITE: count_d = count_q + CNTW'(1);
            OP_READ:  count_d = count_q - CNTW'(1);
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            prio_q  <= prio_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Tag storage needs no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign outs_valid = (count_q != '0);
    assign index      = tag_q[head_q];

endmodule

// File: tb/tb_rr_merge_fifo_dataless.sv
// Self-checking bench: vector table plus a scoreboard-driven random run on a
// 4x4 instance, and hand sequences on SLOTS=3 and SLOTS=1 instances.
module tb_rr_merge_fifo_dataless;

    typedef struct {
        logic       rst;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] eir;
        logic       eov;
        logic [1:0] eidx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] iv4 = '0, iv3 = '0, iv1 = '0;
    logic       or4 = 1'b0, or3 = 1'b0, or1 = 1'b0;
    logic [3:0] ir4, ir3, ir1;
    logic       ov4, ov3, ov1;
    logic [1:0] idx4, idx3, idx1;

    int testsRun  = 0;
    int failCount = 0;
    vec_t vecs[$];
    int sb[$];

    always #5 clk = ~clk;

    rr_merge_fifo_dataless #(.SIZE(4), .SLOTS(4)) dut4 (
        .clk(clk), .rst(rst), .ins_valid(iv4), .ins_ready(ir4),
        .outs_valid(ov4), .outs_ready(or4), .index(idx4)
    );
    rr_merge_fifo_dataless #(.SIZE(4), .SLOTS(3)) dut3 (
        .clk(clk), .rst(rst), .ins_valid(iv3), .ins_ready(ir3),
        .outs_valid(ov3), .outs_ready(or3), .index(idx3)
    );
    rr_merge_fifo_dataless #(.SIZE(4), .SLOTS(1)) dut1 (
        .clk(clk), .rst(rst), .ins_valid(iv1), .ins_ready(ir1),
        .outs_valid(ov1), .outs_ready(or1), .index(idx1)
    );

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r, input logic [3:0] v4, input logic o4,
                                 input logic [3:0] v3, input logic o3,
                                 input logic [3:0] v1, input logic o1);
        @(negedge clk);
        rst = r;
        iv4 = v4; or4 = o4;
        iv3 = v3; or3 = o3;
        iv1 = v1; or1 = o1;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic [3:0] iv, input logic ordy,
                          input logic [3:0] eir, input logic eov, input logic [1:0] eidx);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = ordy; v.eir = eir; v.eov = eov; v.eidx = eidx;
        vecs.push_back(v);
    endtask

    initial begin
        int prioM;
        int w;
        logic [3:0] v;
        logic o;
        logic space;
        logic [3:0] expIr;

        // reset then idle
        addVec(1, 4'b0000, 0, 4'b0000, 0, 0);
        addVec(1, 4'b0000, 0, 4'b0000, 0, 0);
        addVec(0, 4'b0000, 0, 4'b0000, 0, 0);
        addVec(0, 4'b0000, 0, 4'b0000, 0, 0);
        addVec(0, 4'b0000, 1, 4'b0000, 0, 0);
        // all inputs valid, consumer always ready
        addVec(0, 4'b1111, 1, 4'b0001, 0, 0);
        addVec(0, 4'b1111, 1, 4'b0010, 1, 0);
        addVec(0, 4'b1111, 1, 4'b0100, 1, 1);
        addVec(0, 4'b1111, 1, 4'b1000, 1, 2);
        addVec(0, 4'b1111, 1, 4'b0001, 1, 3);
        addVec(0, 4'b1111, 1, 4'b0010, 1, 0);
        addVec(0, 4'b0000, 1, 4'b0000, 1, 1);
        addVec(0, 4'b0000, 1, 4'b0000, 0, 0);
        // fill with 0101, stall when full, then read+write while full
        addVec(1, 4'b0000, 0, 4'b0000, 0, 0);
        addVec(0, 4'b0101, 0, 4'b0001, 0, 0);
        addVec(0, 4'b0101, 0, 4'b0100, 1, 0);
        addVec(0, 4'b0101, 0, 4'b0001, 1, 0);
        addVec(0, 4'b0101, 0, 4'b0100, 1, 0);
        addVec(0, 4'b0101, 0, 4'b0000, 1, 0);
        addVec(0, 4'b0101, 0, 4'b0000, 1, 0);
        addVec(0, 4'b0101, 1, 4'b0001, 1, 0);
        addVec(0, 4'b0101, 0, 4'b0000, 1, 2);
        addVec(0, 4'b0000, 1, 4'b0000, 1, 2);
        addVec(0, 4'b0000, 1, 4'b0000, 1, 0);
        addVec(0, 4'b0000, 1, 4'b0000, 1, 2);
        addVec(0, 4'b0000, 1, 4'b0000, 1, 0);
        addVec(0, 4'b0000, 1, 4'b0000, 0, 0);
        // reset mid-operation with inputs active (prio is 1 here)
        addVec(0, 4'b1111, 0, 4'b0010, 0, 0);
        addVec(0, 4'b1111, 0, 4'b0100, 1, 1);
        addVec(1, 4'b1111, 0, 4'b0000, 0, 0);
        addVec(0, 4'b1111, 0, 4'b0001, 0, 0);
        addVec(0, 4'b1111, 0, 4'b0010, 1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].ordy, 4'b0000, 1'b0, 4'b0000, 1'b0);
            checkOutput($sformatf("vec%0d ins_ready", i), 32'(ir4), 32'(vecs[i].eir));
            if (!vecs[i].rst) begin
                checkOutput($sformatf("vec%0d outs_valid", i), 32'(ov4), 32'(vecs[i].eov));
                if (vecs[i].eov) begin
                    checkOutput($sformatf("vec%0d index", i), 32'(idx4), 32'(vecs[i].eidx));
                end
            end
        end

        // random traffic against a queue-based reference
        applyStimulus(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
        prioM = 0;
        sb.delete();
        for (int c = 0; c < 300; c++) begin
            v = 4'($urandom_range(0, 15));
            o = 1'($urandom_range(0, 1));
            applyStimulus(0, v, o, 4'b0000, 0, 4'b0000, 0);
            space = (sb.size() != 4) || o;
            checkOutput($sformatf("rand%0d outs_valid", c), 32'(ov4), 32'(sb.size() != 0));
            if (sb.size() != 0 && o) begin
                checkOutput($sformatf("rand%0d index", c), 32'(idx4), 32'(sb.pop_front()));
            end
            w = -1;
            for (int k = 3; k >= 0; k--) begin
                if (v[(prioM + k) % 4]) w = (prioM + k) % 4;
            end
            expIr = (w >= 0 && space) ? 4'(1 << w) : 4'b0000;
            checkOutput($sformatf("rand%0d ins_ready", c), 32'(ir4), 32'(expIr));
            if (expIr != 4'b0000) begin
                sb.push_back(w);
                prioM = (w + 1) % 4;
            end
        end

        // SLOTS=3: alternating write/read from input 1, wrapping pointers twice
        applyStimulus(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
        sb.delete();
        for (int n = 0; n < 14; n++) begin
            if (n % 2 == 0) begin
                applyStimulus(0, 4'b0000, 0, 4'b0010, 0, 4'b0000, 0);
                checkOutput($sformatf("s3 alt%0d ins_ready", n), 32'(ir3), 32'(4'b0010));
                checkOutput($sformatf("s3 alt%0d outs_valid", n), 32'(ov3), 32'(0));
                sb.push_back(1);
            end else begin
                applyStimulus(0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 0);
                checkOutput($sformatf("s3 alt%0d outs_valid", n), 32'(ov3), 32'(1));
                checkOutput($sformatf("s3 alt%0d index", n), 32'(idx3), 32'(sb.pop_front()));
                checkOutput($sformatf("s3 alt%0d ins_ready", n), 32'(ir3), 32'(0));
            end
        end
        // SLOTS=3: fill until full, then drain
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 4'b0000, 0, 4'b0010, 0, 4'b0000, 0);
            checkOutput($sformatf("s3 fill%0d ins_ready", k), 32'(ir3), 32'((k < 3) ? 4'b0010 : 4'b0000));
            checkOutput($sformatf("s3 fill%0d outs_valid", k), 32'(ov3), 32'(k != 0));
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 0);
            checkOutput($sformatf("s3 drain%0d outs_valid", k), 32'(ov3), 32'(k < 3));
            if (k < 3) begin
                checkOutput($sformatf("s3 drain%0d index", k), 32'(idx3), 32'(1));
            end
        end

        // SLOTS=1: one token per cycle through a single slot
        applyStimulus(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 4'b0000, 0, 4'b0000, 0, 4'b0010, 1);
            checkOutput($sformatf("s1 run%0d ins_ready", k), 32'(ir1), 32'(4'b0010));
            checkOutput($sformatf("s1 run%0d outs_valid", k), 32'(ov1), 32'(k != 0));
            if (k != 0) begin
                checkOutput($sformatf("s1 run%0d index", k), 32'(idx1), 32'(1));
            end
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 4'b0000, 0, 4'b0000, 0, 4'b0010, 0);
            checkOutput($sformatf("s1 stall%0d ins_ready", k), 32'(ir1), 32'(4'b0000));
            checkOutput($sformatf("s1 stall%0d outs_valid", k), 32'(ov1), 32'(1));
        end
        applyStimulus(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1);
        checkOutput("s1 last index", 32'(idx1), 32'(1));
        applyStimulus(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1);
        checkOutput("s1 empty outs_valid", 32'(ov1), 32'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
